// File: rtl/segway_pkg.sv
// Shared types and constants for the motor command stage.
package segway_pkg;

  // Top-level operating modes of the command stage.
  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RUN       = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } mtr_state_t;

  // Slew prescaler widths: 2^12 clocks normally, 2^4 for fast simulation.
  localparam int PRESC_W_SLOW = 12;
  localparam int PRESC_W_FAST = 4;

  // 12-bit add that clamps at 12'hFFF instead of wrapping.
  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

endpackage

// File: rtl/mtr_slew_ch.sv
// One motor channel: target registers, applied speed/direction and the
// slew/reversal rule applied on each prescaler tick.
module mtr_slew_ch
  import segway_pkg::*;
#(
  parameter int SPD_W        = 11,
  parameter int SLEW_STEP    = 16,
  parameter int DERATE_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,         // stage is OFF: hold everything at zero
  input  logic             load,        // accept a new command this edge
  input  logic             tick,        // slew tick
  input  logic             force_zero,  // ramping down: effective target is 0, rev frozen
  input  logic             derate,      // battery low: scale target down
  input  logic [SPD_W-1:0] cmd_spd,
  input  logic             cmd_rev,
  output logic [SPD_W-1:0] spd,
  output logic             rev,
  output logic             at_tgt
);

  localparam logic [SPD_W-1:0] STEP = SPD_W'(SLEW_STEP);

  logic [SPD_W-1:0] tgt_spd;
  logic             tgt_rev;
  logic [SPD_W-1:0] eff_mag;
  logic [SPD_W-1:0] spd_nxt;
  logic             rev_nxt;
  logic             rev_mismatch;

  // Effective target magnitude and the speed/direction a tick would produce.
  // A direction change first brings the wheel to rest; rev flips only on a
  // tick that finds spd already at zero.
  always_comb begin
    spd_nxt      = spd;
    rev_nxt      = rev;
    eff_mag      = force_zero ? '0 : (derate ? (tgt_spd >> DERATE_SHIFT) : tgt_spd);
    rev_mismatch = (tgt_rev != rev) && !force_zero;
    if (rev_mismatch) begin
      if (spd == '0)       rev_nxt = ~rev;
      else if (spd > STEP) spd_nxt = spd - STEP;
      else                 spd_nxt = '0;
    end else if (eff_mag > spd) begin
      if ((eff_mag - spd) > STEP) spd_nxt = spd + STEP;
      else                        spd_nxt = eff_mag;
    end else if (eff_mag < spd) begin
      if ((spd - eff_mag) > STEP) spd_nxt = spd - STEP;
      else                        spd_nxt = eff_mag;
    end
    // A wheel at rest counts as settled regardless of its direction bit.
    at_tgt = (spd == eff_mag) && ((spd == '0) || (rev == tgt_rev));
  end

  // Target capture and tick-paced update of the applied speed/direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_spd <= '0;
      tgt_rev <= 1'b0;
      spd     <= '0;
      rev     <= 1'b0;
    end else if (clr) begin
      tgt_spd <= '0;
      tgt_rev <= 1'b0;
      spd     <= '0;
    end else begin
      if (tick) begin
        spd <= spd_nxt;
        rev <= rev_nxt;
      end
      if (load) begin
        tgt_spd <= cmd_spd;
        tgt_rev <= cmd_rev;
      end
    end
  end

endmodule

// File: rtl/mtr_cmd_stage.sv
// Motor command stage: power/rider FSM, slew prescaler, battery-low
// detection with hysteresis and one slew channel per motor.
//
// vld is a one-cycle strobe with no back-pressure: a command is taken on any
// clk edge where vld=1 and the stage is in RUN and not leaving it; otherwise
// it is dropped.
module mtr_cmd_stage
  import segway_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          SPD_W        = 11,
  parameter int          SLEW_STEP    = 16,
  parameter logic [11:0] BATT_LOW_TH  = 12'h800,
  parameter logic [11:0] BATT_HYST    = 12'h040,
  parameter int          DERATE_SHIFT = 1,
  parameter int          FAST_SIM     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pwr_up,
  input  logic                    vld,
  input  logic [NUM_CH*SPD_W-1:0] cmd_spd,
  input  logic [NUM_CH-1:0]       cmd_rev,
  input  logic                    rider_off,
  input  logic [11:0]             batt,
  output logic [NUM_CH*SPD_W-1:0] spd,
  output logic [NUM_CH-1:0]       rev,
  output logic                    moving,
  output logic                    batt_low,
  output logic                    ramp_busy
);

  localparam int          PW          = (FAST_SIM != 0) ? PRESC_W_FAST : PRESC_W_SLOW;
  localparam logic [11:0] BATT_CLR_TH = sat_add12(BATT_LOW_TH, BATT_HYST);

  mtr_state_t        state;
  mtr_state_t        state_nxt;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              stop_req;
  logic              load;
  logic [NUM_CH-1:0] ch_at_tgt;

  assign tick     = &presc;
  assign stop_req = !pwr_up || rider_off;
  assign load     = (state == ST_RUN) && !stop_req && vld;
  assign moving   = (spd != '0);
  assign ramp_busy = (state == ST_RAMP_DOWN) || !(&ch_at_tgt);

  // Free-running slew prescaler; tick fires when it wraps.
  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= presc + 1'b1;
  end

  // Battery-low flag with hysteresis between set and clear thresholds.
  always_ff @(posedge clk) begin
    if (rst)                      batt_low <= 1'b0;
    else if (batt < BATT_LOW_TH)  batt_low <= 1'b1;
    else if (batt >= BATT_CLR_TH) batt_low <= 1'b0;
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_OFF;
    else     state <= state_nxt;
  end

  // Mode transitions; leaving RAMP_DOWN waits until every wheel is at rest.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:       if (pwr_up && !rider_off) state_nxt = ST_RUN;
      ST_RUN:       if (stop_req)             state_nxt = ST_RAMP_DOWN;
      ST_RAMP_DOWN: begin
        if (!moving) begin
          if (!pwr_up)         state_nxt = ST_OFF;
          else if (!rider_off) state_nxt = ST_RUN;
        end
      end
      default:                                state_nxt = ST_OFF;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mtr_slew_ch #(
      .SPD_W        (SPD_W),
      .SLEW_STEP    (SLEW_STEP),
      .DERATE_SHIFT (DERATE_SHIFT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clr        (state == ST_OFF),
      .load       (load),
      .tick       (tick),
      .force_zero (state == ST_RAMP_DOWN),
      .derate     (batt_low),
      .cmd_spd    (cmd_spd[i*SPD_W +: SPD_W]),
      .cmd_rev    (cmd_rev[i]),
      .spd        (spd[i*SPD_W +: SPD_W]),
      .rev        (rev[i]),
      .at_tgt     (ch_at_tgt[i])
    );
  end

endmodule

// File: tb/tb_mtr_cmd_stage.sv
// Bench for mtr_cmd_stage: directed scenarios plus a random phase, with every
// cycle compared against a cycle-level behavioural model of the spec rules.
module tb_mtr_cmd_stage;

  localparam int NCH   = 4;
  localparam int SW    = 12;
  localparam int STEP  = 16;
  localparam int TH    = 'h800;
  localparam int HYST  = 'h040;
  localparam int DS    = 1;
  localparam int PER   = 16;  // slew tick period with FAST_SIM=1

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 pwr_up = 1'b0;
  logic                 vld = 1'b0;
  logic [NCH*SW-1:0]    cmd_spd = '0;
  logic [NCH-1:0]       cmd_rev = '0;
  logic                 rider_off = 1'b0;
  logic [11:0]          batt = 12'hFFF;
  logic [NCH*SW-1:0]    spd;
  logic [NCH-1:0]       rev;
  logic                 moving, batt_low, ramp_busy;

  mtr_cmd_stage #(
    .NUM_CH(NCH), .SPD_W(SW), .SLEW_STEP(STEP), .BATT_LOW_TH(12'h800),
    .BATT_HYST(12'h040), .DERATE_SHIFT(DS), .FAST_SIM(1)
  ) dut (
    .clk(clk), .rst(rst), .pwr_up(pwr_up), .vld(vld), .cmd_spd(cmd_spd),
    .cmd_rev(cmd_rev), .rider_off(rider_off), .batt(batt), .spd(spd), .rev(rev),
    .moving(moving), .batt_low(batt_low), .ramp_busy(ramp_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: mode 0=off 1=run 2=ramping down
  int m_mode = 0, m_cnt = 0, m_blow = 0;
  int m_tgt[NCH], m_trev[NCH], m_spd[NCH], m_rev[NCH];

  function automatic int eff_of(input int c);
    if (m_mode == 2) return 0;
    return (m_blow != 0) ? (m_tgt[c] >> DS) : m_tgt[c];
  endfunction

  function automatic int dut_spd(input int c);
    return int'(spd[c*SW +: SW]);
  endfunction

  // advance the model by one clock edge using the inputs now applied
  task automatic model_step();
    int any_moving, is_tick, e;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_blow = 0;
      for (int c = 0; c < NCH; c++) begin
        m_tgt[c] = 0; m_trev[c] = 0; m_spd[c] = 0; m_rev[c] = 0;
      end
      return;
    end
    is_tick = (m_cnt == PER - 1);
    m_cnt = (m_cnt + 1) % PER;
    any_moving = 0;
    for (int c = 0; c < NCH; c++) if (m_spd[c] != 0) any_moving = 1;
    for (int c = 0; c < NCH; c++) begin
      e = eff_of(c);
      if (m_mode == 0) begin
        m_spd[c] = 0; m_tgt[c] = 0; m_trev[c] = 0;
      end else begin
        if (is_tick) begin
          if (m_trev[c] != m_rev[c] && m_mode != 2) begin
            if (m_spd[c] == 0) m_rev[c] = 1 - m_rev[c];
            else m_spd[c] = (m_spd[c] > STEP) ? m_spd[c] - STEP : 0;
          end else if (e > m_spd[c]) begin
            m_spd[c] = (m_spd[c] + STEP < e) ? m_spd[c] + STEP : e;
          end else begin
            m_spd[c] = (m_spd[c] - STEP > e) ? m_spd[c] - STEP : e;
          end
        end
        if (m_mode == 1 && pwr_up && !rider_off && vld) begin
          m_tgt[c] = int'(cmd_spd[c*SW +: SW]);
          m_trev[c] = int'(cmd_rev[c]);
        end
      end
    end
    if (int'(batt) < TH) m_blow = 1;
    else if (int'(batt) >= ((TH + HYST > 'hFFF) ? 'hFFF : TH + HYST)) m_blow = 0;
    case (m_mode)
      0: if (pwr_up && !rider_off) m_mode = 1;
      1: if (!pwr_up || rider_off) m_mode = 2;
      default: if (!any_moving) begin
        if (!pwr_up) m_mode = 0;
        else if (!rider_off) m_mode = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    int mv, busy;
    mv = 0; busy = (m_mode == 2);
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("spd%0d", c), dut_spd(c), m_spd[c]);
      check_val($sformatf("rev%0d", c), int'(rev[c]), m_rev[c]);
      if (m_spd[c] != 0) mv = 1;
      if (!(m_spd[c] == eff_of(c) && (m_spd[c] == 0 || m_rev[c] == m_trev[c]))) busy = 1;
    end
    check_val("moving", int'(moving), mv);
    check_val("batt_low", int'(batt_low), m_blow);
    check_val("ramp_busy", int'(ramp_busy), busy);
  endtask

  // scoreboard for the first ramp-up sequence of channel 0
  logic [SW-1:0] exp_q[$];
  bit track_en = 0;
  int cyc_n = 0, last_spd0 = 0, last_chg = -1;

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    compare_all();
    if (track_en && dut_spd(0) != last_spd0) begin
      if (exp_q.size() == 0) check_val("seq_extra", dut_spd(0), last_spd0);
      else check_val("seq_val", dut_spd(0), int'(exp_q.pop_front()));
      if (last_chg >= 0) check_val("tick_gap", cyc_n - last_chg, PER);
      last_chg = cyc_n;
    end
    last_spd0 = dut_spd(0);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // driver: one-cycle command strobe with the same command on every channel
  // unless per-channel values were set beforehand
  task automatic set_ch(input int c, input int mag, input bit r);
    cmd_spd[c*SW +: SW] = SW'(mag);
    cmd_rev[c] = r;
  endtask

  task automatic send_all(input int mag, input bit r);
    for (int c = 0; c < NCH; c++) set_ch(c, mag, r);
    vld = 1; cyc(); vld = 0;
  endtask

  int waited;

  initial begin
    // reset
    run(3);
    rst = 0;
    check_val("rst_spd0", dut_spd(0), 0);
    check_val("rst_busy", int'(ramp_busy), 0);

    // ramp-up 0 -> 100 on channel 0
    pwr_up = 1;
    cyc();
    for (int v = 16; v <= 96; v += 16) exp_q.push_back(SW'(v));
    exp_q.push_back(SW'(100));
    track_en = 1;
    set_ch(0, 100, 0); set_ch(1, 0, 0); set_ch(2, 0, 0); set_ch(3, 0, 0);
    vld = 1; cyc(); vld = 0;
    run(10 * PER);
    track_en = 0;
    check_val("seq_left", exp_q.size(), 0);
    check_val("up_final", dut_spd(0), 100);
    check_val("up_moving", int'(moving), 1);

    // reversal: settle at 64, then ask for 32 reversed
    send_all(64, 0);
    run(5 * PER);
    check_val("rev_pre", dut_spd(0), 64);
    send_all(32, 1);
    run(10 * PER);
    check_val("rev_spd", dut_spd(0), 32);
    check_val("rev_dir", int'(rev[0]), 1);

    // battery derate and hysteresis
    send_all(400, 0);
    run(35 * PER);
    check_val("batt_pre", dut_spd(1), 400);
    batt = 12'h7FF; cyc();
    check_val("batt_set", int'(batt_low), 1);
    run(20 * PER);
    check_val("derated", dut_spd(1), 200);
    batt = 12'h820; run(2 * PER);
    check_val("batt_hold", int'(batt_low), 1);
    batt = 12'h840; cyc();
    check_val("batt_clr", int'(batt_low), 0);
    run(20 * PER);
    check_val("restored", dut_spd(1), 400);

    // rider off: ramp down, commands ignored, resume with old targets
    send_all(48, 0);
    run(25 * PER);
    rider_off = 1;
    send_all(500, 0);
    send_all(700, 0);
    run(5 * PER);
    check_val("rd_zero", dut_spd(0), 0);
    rider_off = 0;
    run(6 * PER);
    check_val("rd_resume", dut_spd(0), 48);

    // power down to OFF, then reset mid-ramp
    pwr_up = 0;
    run(6 * PER);
    check_val("off_busy", int'(ramp_busy), 0);
    pwr_up = 1; cyc();
    send_all(48, 0);
    run(5 * PER);
    pwr_up = 0;
    run(PER + 3);
    rst = 1; cyc(); rst = 0;
    check_val("midrst_spd", dut_spd(0), 0);
    check_val("midrst_mov", int'(moving), 0);

    // independent channel targets
    pwr_up = 1; cyc();
    set_ch(0, 0, 0); set_ch(1, 4095, 0); set_ch(2, 17, 0); set_ch(3, 16, 0);
    vld = 1; cyc(); vld = 0;
    waited = 0;
    while (ramp_busy && waited < 270 * PER) begin
      cyc(); waited++;
    end
    check_val("indep_timeout", int'(ramp_busy), 0);
    check_val("indep0", dut_spd(0), 0);
    check_val("indep1", dut_spd(1), 4095);
    check_val("indep2", dut_spd(2), 17);
    check_val("indep3", dut_spd(3), 16);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      vld = ($urandom_range(0, 9) == 0);
      for (int c = 0; c < NCH; c++) set_ch(c, $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 399) == 0) pwr_up = ~pwr_up;
      if ($urandom_range(0, 299) == 0) rider_off = ~rider_off;
      if ($urandom_range(0, 49) == 0) batt = 12'($urandom_range('h7C0, 'h860));
      rst = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    rst = 0; vld = 0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mtr_cmd_stage.md
MTR_CMD_STAGE -- requirements
Module: mtr_cmd_stage

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, number of motor channels.
REQ-002 SHALL provide parameter SPD_W, default 11, speed magnitude width.
REQ-003 SHALL provide parameter SLEW_STEP, default 16, max magnitude change per slew tick.
REQ-004 SHALL provide parameter BATT_LOW_TH, default 12'h800, battery-low set threshold.
REQ-005 SHALL provide parameter BATT_HYST, default 12'h040, battery-low clear hysteresis.
REQ-006 SHALL provide parameter DERATE_SHIFT, default 1, right-shift applied to targets while batt_low.
REQ-007 SHALL provide parameter FAST_SIM, default 0, selects a short slew prescaler.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset; pwr_up in 1 enable; vld in 1 command strobe; cmd_spd in NUM_CH x SPD_W target magnitude; cmd_rev in NUM_CH target direction; rider_off in 1; batt in 12 battery reading; spd out NUM_CH x SPD_W applied magnitude; rev out NUM_CH applied direction; moving out 1; batt_low out 1; ramp_busy out 1.
REQ-009 SHALL use a single clock, clk; reset rst is synchronous and active-high.

Function
REQ-010 SHALL latch cmd_spd/cmd_rev into per-channel target registers only on clk edges with vld=1 while in RUN.
REQ-011 SHALL generate a one-cycle slew tick every 2^12 clocks (FAST_SIM=0) or 2^4 clocks (FAST_SIM=1) from a free-running prescaler.
REQ-012 SHALL, on each slew tick, move each channel's spd toward its effective target by min(SLEW_STEP, |difference|); no change between ticks.
REQ-013 SHALL, when target direction differs from rev, slew spd toward 0 and toggle rev only on a tick where spd is already 0.
REQ-014 SHALL compute effective target as target >> DERATE_SHIFT while batt_low=1, else target unmodified.
REQ-015 SHALL set batt_low when batt < BATT_LOW_TH and clear it when batt >= BATT_LOW_TH + BATT_HYST (saturating at 12'hFFF); otherwise hold; registered, 1-cycle latency.
REQ-016 SHALL implement states OFF, RUN, RAMP_DOWN.
REQ-017 OFF: spd=0, targets=0; go RUN when pwr_up=1 and rider_off=0.
REQ-018 RUN: go RAMP_DOWN when pwr_up=0 or rider_off=1; vld in that same cycle is ignored.
REQ-019 RAMP_DOWN: effective targets forced to 0, rev held; go OFF when all spd=0 and pwr_up=0; go RUN when all spd=0, pwr_up=1, rider_off=0; stay otherwise.
REQ-020 SHALL drive moving=1 whenever any channel spd != 0.
REQ-021 SHALL drive ramp_busy=1 in RAMP_DOWN or when any spd differs from its effective target.
REQ-022 SHALL treat channels independently; a reversing channel does not stall others.

Reset
REQ-023 SHALL on rst=1 set state OFF, all spd=0, rev=0, targets=0, prescaler=0, batt_low=0, moving=0, ramp_busy=0.
REQ-024 SHALL let rst asserted mid-ramp zero outputs on the next clk edge with no ramp.

Structure
REQ-025 SHALL place the state enum and the prescaler-width constants (12 and 4) in shared package segway_pkg.
REQ-026 SHALL instantiate one sub-module per channel, mtr_slew_ch, holding target, spd, rev and the slew/reversal logic.

Verification
REQ-027 Reset then pwr_up=1, vld with cmd_spd=100, FAST_SIM=1 -> spd 0,16,...,96,100 on successive ticks (16 clocks apart), moving=1.
REQ-028 At spd=64 rev=0, vld with cmd_spd=32 cmd_rev=1 -> spd 48,32,16,0, rev toggles on the tick spd is 0, then 16,32.
REQ-029 Steady spd=400, batt driven 12'h7FF -> batt_low=1 next cycle, spd slews to 200; batt 12'h820 keeps batt_low=1; batt 12'h840 clears it, spd returns to 400.
REQ-030 spd=48 in RUN, rider_off=1 -> RAMP_DOWN, vld ignored, spd 32,16,0, then RUN when rider_off=0 with targets unchanged.
REQ-031 spd=48, pwr_up=0 -> ramp to 0 then OFF; rst asserted mid-ramp -> spd=0, state OFF next edge.
REQ-032 NUM_CH=4, SPD_W=12: independent targets 0, 4095, 17, 16 -> each reaches target; ramp_busy falls only when all match.
